bus_gate_arbiter: RTL
=====================

BUS_GATE_ARBITER -- requirements
Module: bus_gate_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the bus and source data width.
REQ-002 Parameter TIMEOUT, default 15, SHALL set the maximum grant length in cycles (range 1..255).
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be the reset: synchronous and active-high.
REQ-005 Port req, input, 4 bits, SHALL carry one request bit per source: 0=PC, 1=MDR, 2=ALU, 3=MARMUX.
REQ-006 Port done, input, 4 bits, SHALL carry one release strobe per source.
REQ-007 Ports d0, d1, d2, d3, input, WIDTH bits each, SHALL carry the source data.
REQ-008 Port bus, output, WIDTH bits, SHALL carry the shared-bus value.
REQ-009 Port gate, output, 4 bits, SHALL be the one-hot gate enables (GatePC/MDR/ALU/MARMUX).
REQ-010 Port sel, output, 2 bits, SHALL be the registered index of the granted source.
REQ-011 Port busy, output, 1 bit, SHALL be high while in GRANT.
REQ-012 Port timeout, output, 1 bit, SHALL pulse for one cycle on a forced release.

Function
REQ-013 FSM SHALL have two states, IDLE and GRANT.
REQ-014 IDLE: if req!=0, SHALL pick the first set req bit scanning ptr, ptr+1, ... mod 4; register sel, set gate one-hot, go to GRANT next cycle.
REQ-015 Latency SHALL be exactly 1 cycle: req sampled in IDLE at edge n -> gate/busy high after edge n+1.
REQ-016 GRANT: gate SHALL equal 1<<sel, busy=1, bus=d[sel].
REQ-017 Outside GRANT: gate=0, busy=0, bus=0 (no source driven).
REQ-018 GRANT SHALL end when done[sel]=1 or req[sel]=0; next state IDLE, ptr<=sel+1 mod 4 (wraps 3->0).
REQ-019 done bits of non-granted sources, and all done bits in IDLE, SHALL be ignored.
REQ-020 Release to new grant SHALL take 2 cycles, because IDLE is a mandatory one-cycle bus-turnaround slot.
REQ-021 Requests arriving during GRANT SHALL be held off and arbitrated in the following IDLE cycle.
REQ-022 If the granted source's req falls and done rises in the same cycle, this SHALL be a single release.
REQ-023 gate SHALL never have more than one bit set in any cycle.

Reset
REQ-024 When rst=1 at a clock edge, the next state SHALL be IDLE, ptr=0, sel=0, gate=0, busy=0, timeout=0, counter=0, and bus=0.
REQ-025 Reset asserted mid-GRANT SHALL drop gate on the next edge, with no release or ptr advance recorded.
REQ-026 rst SHALL take priority over every other input.

Configuration
REQ-027 Macro BUS_ARB_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entry to GRANT and increment each GRANT cycle.
REQ-028 With BUS_ARB_TIMEOUT_EN, after TIMEOUT GRANT cycles without a release, the block SHALL force a release as in REQ-018, with ptr advancing.
REQ-029 With BUS_ARB_TIMEOUT_EN, timeout SHALL be 1 for exactly the first IDLE cycle after a forced release.
REQ-030 Macro undefined: no counter SHALL exist, timeout SHALL be tied 0, and grants SHALL be unbounded.

Structure
REQ-031 Package lc3_bus_pkg SHALL hold the state enum (IDLE, GRANT), source index constants SRC_PC=0, SRC_MDR=1, SRC_ALU=2, SRC_MARMUX=3, and default TIMEOUT.
REQ-032 bus_gate_arbiter SHALL instantiate one sub-module, bus_mux4 (WIDTH-parameterised 4:1 mux with enable), to drive bus from sel and busy.

Verification
REQ-033 Reset, then req=4'b0100 -> after 1 cycle gate=4'b0100, sel=2, bus=d2; done=4'b0100 -> next cycle gate=0, ptr=3.
REQ-034 From ptr=0, req=4'b1111 held with done pulsed on the granted source -> grant order 0,1,2,3,0, each grant separated by one IDLE cycle.
REQ-035 In GRANT of source 1, pulse done=4'b0001 -> ignored, grant held; then req[1]=0 -> release.
REQ-036 rst=1 during GRANT of source 3 -> next cycle gate=0, busy=0, ptr=0; then req=4'b1000 -> source 3 re-granted.
REQ-037 BUS_ARB_TIMEOUT_EN defined, TIMEOUT=4, source 0 holds req with no done -> gate drops after 4 GRANT cycles, timeout=1 for one cycle, source 1 (req high) granted next.
REQ-038 Every test SHALL include a continuous assertion that gate is one-hot or zero and that bus=0 whenever busy=0.

Source files
------------

// File: rtl/lc3_bus_pkg.sv
// Shared definitions for the LC-3 style shared-bus gate arbiter:
// FSM state encoding, source index constants, default grant limit and
// the rotating-priority pick helper.
package lc3_bus_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam logic [1:0] SRC_PC     = 2'd0;
    localparam logic [1:0] SRC_MDR    = 2'd1;
    localparam logic [1:0] SRC_ALU    = 2'd2;
    localparam logic [1:0] SRC_MARMUX = 2'd3;

    localparam int DEF_TIMEOUT = 15;

    // First set request bit scanning ptr, ptr+1, ... modulo 4.
    // Returns ptr when nothing is requested (caller qualifies with req != 0).
    function automatic logic [1:0] pick_first(input logic [3:0] req_v,
                                              input logic [1:0] ptr_v);
        logic [1:0] idx_s;
        logic       found_s;
        pick_first = ptr_v;
        found_s    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx_s = ptr_v + i[1:0];
            if (!found_s && req_v[idx_s]) begin
                pick_first = idx_s;
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    endfunction

endpackage

// File: rtl/bus_mux4.sv
// 4:1 bus multiplexer with enable: drives the selected source onto the
// bus only while enabled, otherwise the bus reads as all zeros.
module bus_mux4 #(
    parameter int WIDTH = 16
) (
    input  logic [1:0]       sel,
    input  logic             en,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [WIDTH-1:0] y
);

    // Select the granted source; nothing is driven when disabled.
    always_comb begin
        y = {WIDTH{1'b0}};
        if (en) begin
            case (sel)
                2'd0:    y = d0;
                2'd1:    y = d1;
                2'd2:    y = d2;
                2'd3:    y = d3;
                default: y = {WIDTH{1'b0}};
            endcase
        end else begin
            y = {WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/bus_gate_arbiter.sv
// Shared-bus gate arbiter: four sources (PC, MDR, ALU, MARMUX) compete for
// one bus. Rotating priority starting at ptr; a mandatory one-cycle IDLE
// slot separates consecutive grants (bus turnaround).
// Optional feature: define BUS_ARB_TIMEOUT_EN to bound each grant to
// TIMEOUT cycles, with a one-cycle timeout pulse after a forced release.
module bus_gate_arbiter
    import lc3_bus_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [3:0]       done,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [WIDTH-1:0] bus,
    output logic [3:0]       gate,
    output logic [1:0]       sel,
    output logic             busy,
    output logic             timeout
);

    arb_state_e state_r, state_s;
    logic [1:0] ptr_r,   ptr_s;
    logic [1:0] sel_r,   sel_s;
    logic [3:0] gate_r,  gate_s;
    logic       busy_r,  busy_s;
    logic [1:0] pick_s;
    logic       release_s;
    logic       forced_s;

`ifdef BUS_ARB_TIMEOUT_EN
    // Last GRANT cycle index before a forced release (counter starts at 0).
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_r, cnt_s;
    logic       timeout_r, timeout_s;
`else
    logic       unused_cfg_s;
    assign unused_cfg_s = |TIMEOUT;
`endif

    assign pick_s = pick_first(req, ptr_r);

    // Next-state, grant selection and release decision.
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        sel_s     = sel_r;
        gate_s    = gate_r;
        busy_s    = busy_r;
        release_s = 1'b0;
        forced_s  = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
        cnt_s     = cnt_r;
        timeout_s = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_s = GRANT;
                    sel_s   = pick_s;
                    gate_s  = 4'b0001 << pick_s;
                    busy_s  = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
                    cnt_s   = 8'd0;
`endif
                end else begin
                    state_s = IDLE;
                    gate_s  = 4'b0000;
                    busy_s  = 1'b0;
                end
            end
            GRANT: begin
                // Only the granted source's done/req matter here.
                release_s = done[sel_r] | ~req[sel_r];
`ifdef BUS_ARB_TIMEOUT_EN
                forced_s  = (cnt_r == TO_LAST) & ~release_s;
`endif
                if (release_s || forced_s) begin
                    state_s = IDLE;
                    ptr_s   = sel_r + 2'd1;
                    gate_s  = 4'b0000;
                    busy_s  = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
                    timeout_s = forced_s;
`endif
                end else begin
                    state_s = GRANT;
`ifdef BUS_ARB_TIMEOUT_EN
                    cnt_s   = cnt_r + 8'd1;
`endif
                end
            end
            default: begin
                state_s = IDLE;
                gate_s  = 4'b0000;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            ptr_r   <= SRC_PC;
            sel_r   <= SRC_PC;
            gate_r  <= 4'b0000;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            sel_r   <= sel_s;
            gate_r  <= gate_s;
            busy_r  <= busy_s;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    // Grant-length counter and forced-release pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= 8'd0;
            timeout_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_s;
            timeout_r <= timeout_s;
        end
    end

    assign timeout = timeout_r;
`else
    assign timeout = 1'b0;
`endif

    assign gate = gate_r;
    assign sel  = sel_r;
    assign busy = busy_r;

    bus_mux4 #(.WIDTH(WIDTH)) u_mux (
        .sel (sel_r),
        .en  (busy_r),
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .y   (bus)
    );

endmodule
